sipo_frame_deserializer: RTL and testbench

Parametrised serial-in/parallel-out deserialiser, generalising the fixed 8-bit SIPO shift register to WIDTH bits with selectable bit order. Adds:
- a shift-enable input;
- frame resynchronisation;
- a word-boundary bit counter;
- a holding register with a valid/ready output handshake;
- a sticky overrun flag.

It sits between a serial link front-end and word-oriented consumer logic.

---
 rtl/sipo_pkg.sv | 14 +
 rtl/sipo_frame_deserializer_if.sv | 23 ++
 rtl/sipo_bit_counter.sv | 44 ++++
 rtl/sipo_frame_deserializer.sv | 108 ++++++++++
 tb/tb_sipo_frame_deserializer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-in/parallel-out frame deserialiser.
package sipo_pkg;

    localparam int SHIFT_LSB_FIRST = 0;
    localparam int SHIFT_MSB_FIRST = 1;
    localparam int WIDTH_MIN       = 2;
    localparam int WIDTH_MAX       = 64;

    // Bit-counter width able to hold 0..width-1.
    function automatic int count_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_frame_deserializer_if.sv
// Word-side output bus of the deserialiser (producer = master, consumer = slave).
interface sipo_frame_deserializer_if #(
    parameter int WIDTH = 8
);
    // Valid/ready: a word transfers on any clock edge where Out_Valid_Out and
    // Out_Ready_In are both 1; while Out_Valid_Out is 1 the word is held
    // stable unless a newer completed word overwrites it (overrun).
    logic [WIDTH-1:0] Parallel_Data_Out;
    logic             Out_Valid_Out;
    logic             Out_Ready_In;

    modport master (
        output Parallel_Data_Out,
        output Out_Valid_Out,
        input  Out_Ready_In
    );

    modport slave (
        input  Parallel_Data_Out,
        input  Out_Valid_Out,
        output Out_Ready_In
    );
endinterface

// File: rtl/sipo_bit_counter.sv
// Word-boundary bit counter: counts enabled edges 0..WIDTH-1 and flags the last bit.
module sipo_bit_counter
    import sipo_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_in,
    input  logic               clr_in,
    input  logic               load_one_in,
    output logic [COUNT_W-1:0] count_out,
    output logic               last_bit_out
);

    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               last_bit;

    assign last_bit = (count_q == COUNT_W'(WIDTH - 1));

    always_comb begin
        count_d = count_q;
        if (clr_in) begin
            // A bit sampled on the clearing edge is the first bit of the new frame.
            count_d = load_one_in ? COUNT_W'(1) : '0;
        end else if (en_in) begin
            count_d = last_bit ? '0 : count_q + COUNT_W'(1);
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out    = count_q;
    assign last_bit_out = last_bit;

endmodule

// File: rtl/sipo_frame_deserializer.sv
// Serial-in/parallel-out deserialiser with frame resync, holding register,
// valid/ready output and sticky overrun flag; all state moves on the falling edge.
module sipo_frame_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = SHIFT_LSB_FIRST,
    parameter int COUNT_W   = count_width(WIDTH)
) (
    input  logic                       Clk_In,
    input  logic                       Reset_In,
    input  logic                       Shift_En_In,
    input  logic                       Serial_Data_In,
    input  logic                       Frame_Sync_In,
    input  logic                       Overrun_Clr_In,
    sipo_frame_deserializer_if.master  out_if,
    output logic                       Overrun_Out,
    output logic [COUNT_W-1:0]         Bit_Count_Out,
    output logic [WIDTH-1:0]           Shift_Register_Out
);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] sr_shifted;
    logic [WIDTH-1:0] sr_first_bit;
    logic             last_bit;
    logic             complete;

    sipo_bit_counter #(
        .WIDTH   (WIDTH),
        .COUNT_W (COUNT_W)
    ) u_bit_counter (
        .clk          (Clk_In),
        .rst          (Reset_In),
        .en_in        (Shift_En_In),
        .clr_in       (Frame_Sync_In),
        .load_one_in  (Shift_En_In),
        .count_out    (Bit_Count_Out),
        .last_bit_out (last_bit)
    );

    // Frame sync outranks completion, so a resync edge never emits a word.
    assign complete = Shift_En_In && last_bit && !Frame_Sync_In;

    always_comb begin
        sr_shifted   = '0;
        sr_first_bit = '0;
        if (MSB_FIRST != SHIFT_LSB_FIRST) begin
            sr_shifted      = {sr_q[WIDTH-2:0], Serial_Data_In};
            sr_first_bit[0] = Serial_Data_In;
        end else begin
            sr_shifted            = {Serial_Data_In, sr_q[WIDTH-1:1]};
            sr_first_bit[WIDTH-1] = Serial_Data_In;
        end
    end

    always_comb begin
        sr_d      = sr_q;
        hold_d    = hold_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (Frame_Sync_In) begin
            sr_d = Shift_En_In ? sr_first_bit : '0;
        end else if (Shift_En_In) begin
            sr_d = sr_shifted;
        end

        if (valid_q && out_if.Out_Ready_In) begin
            valid_d = 1'b0;
        end
        if (Overrun_Clr_In) begin
            overrun_d = 1'b0;
        end

        // Newest word wins; losing an unaccepted word is recorded, and that
        // set takes priority over a simultaneous clear.
        if (complete) begin
            hold_d  = sr_shifted;
            valid_d = 1'b1;
            if (valid_q && !out_if.Out_Ready_In) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            sr_q      <= '0;
            hold_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            hold_q    <= hold_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_if.Parallel_Data_Out = hold_q;
    assign out_if.Out_Valid_Out     = valid_q;
    assign Overrun_Out              = overrun_q;
    assign Shift_Register_Out       = sr_q;

endmodule

// File: tb/tb_sipo_frame_deserializer.sv
// Directed bench for sipo_frame_deserializer: LSB-first and MSB-first 8-bit
// instances plus a 5-bit instance, all fed from the same serial stimulus.
module tb_sipo_frame_deserializer;

    logic clk;
    logic rst;
    logic shift_en;
    logic serial_d;
    logic frame_sync;
    logic ready;
    logic ovr_clr;

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    sipo_frame_deserializer_if #(.WIDTH(8)) if8  ();
    sipo_frame_deserializer_if #(.WIDTH(8)) if8m ();
    sipo_frame_deserializer_if #(.WIDTH(5)) if5  ();

    assign if8.Out_Ready_In  = ready;
    assign if8m.Out_Ready_In = ready;
    assign if5.Out_Ready_In  = ready;

    logic       ovr8, ovr8m, ovr5;
    logic [2:0] cnt8, cnt8m, cnt5;
    logic [7:0] sr8, sr8m;
    logic [4:0] sr5;

    sipo_frame_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut8 (
        .Clk_In (clk), .Reset_In (rst), .Shift_En_In (shift_en),
        .Serial_Data_In (serial_d), .Frame_Sync_In (frame_sync),
        .Overrun_Clr_In (ovr_clr), .out_if (if8), .Overrun_Out (ovr8),
        .Bit_Count_Out (cnt8), .Shift_Register_Out (sr8)
    );

    sipo_frame_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut8m (
        .Clk_In (clk), .Reset_In (rst), .Shift_En_In (shift_en),
        .Serial_Data_In (serial_d), .Frame_Sync_In (frame_sync),
        .Overrun_Clr_In (ovr_clr), .out_if (if8m), .Overrun_Out (ovr8m),
        .Bit_Count_Out (cnt8m), .Shift_Register_Out (sr8m)
    );

    sipo_frame_deserializer #(.WIDTH(5), .MSB_FIRST(0)) dut5 (
        .Clk_In (clk), .Reset_In (rst), .Shift_En_In (shift_en),
        .Serial_Data_In (serial_d), .Frame_Sync_In (frame_sync),
        .Overrun_Clr_In (ovr_clr), .out_if (if5), .Overrun_Out (ovr5),
        .Bit_Count_Out (cnt5), .Shift_Register_Out (sr5)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp5_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver: apply inputs away from the falling edge, return just after it
    task automatic step(input logic sh, input logic d, input logic sync,
                        input logic rdy, input logic clr);
        @(posedge clk);
        shift_en   = sh;
        serial_d   = d;
        frame_sync = sync;
        ready      = rdy;
        ovr_clr    = clr;
        @(negedge clk);
        #1;
    endtask

    // send a byte LSB first; ready is raised only on the final bit's edge
    task automatic send_byte(input logic [7:0] b, input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, b[i], 1'b0, (i == 7) ? rdy_last : 1'b0, 1'b0);
        end
    endtask

    task automatic sb_check8(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 64'(if8.Parallel_Data_Out), 64'(e));
        end
    endtask

    task automatic sb_check5(input string tag);
        logic [7:0] e;
        if (exp5_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(exp5_q.size()), 64'd1);
        end else begin
            e = exp5_q.pop_front();
            chk(tag, 64'(if5.Parallel_Data_Out), 64'(e));
        end
    endtask

    initial begin
        rst        = 1'b1;
        shift_en   = 1'b0;
        serial_d   = 1'b0;
        frame_sync = 1'b0;
        ready      = 1'b0;
        ovr_clr    = 1'b0;
        #12;
        chk("rst_data",  64'(if8.Parallel_Data_Out), 64'd0);
        chk("rst_valid", 64'(if8.Out_Valid_Out), 64'd0);
        chk("rst_ovr",   64'(ovr8), 64'd0);
        chk("rst_cnt",   64'(cnt8), 64'd0);
        chk("rst_sr",    64'(sr8), 64'd0);
        rst = 1'b0;

        // LSB-first and MSB-first views of stream 1,0,1,1,0,0,1,0
        exp_q.push_back(8'h4D);
        send_byte(8'h4D, 1'b0);
        sb_check8("t1_word");
        chk("t1_valid", 64'(if8.Out_Valid_Out), 64'd1);
        chk("t1_cnt",   64'(cnt8), 64'd0);
        chk("t1_ovr",   64'(ovr8), 64'd0);
        chk("t2_msb_word",  64'(if8m.Parallel_Data_Out), 64'hB2);
        chk("t2_msb_valid", 64'(if8m.Out_Valid_Out), 64'd1);

        // overrun: two more words with no acceptance
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b0);
        sb_check8("t3_word_a5");
        chk("t3_ovr_a5", 64'(ovr8), 64'd1);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b0);
        sb_check8("t3_word_3c");
        chk("t3_ovr_3c", 64'(ovr8), 64'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_ovr_clr",    64'(ovr8), 64'd0);
        chk("t3_valid_kept", 64'(if8.Out_Valid_Out), 64'd1);

        // completion on the same edge as acceptance
        exp_q.push_back(8'h96);
        send_byte(8'h96, 1'b1);
        sb_check8("t4_word");
        chk("t4_valid", 64'(if8.Out_Valid_Out), 64'd1);
        chk("t4_ovr",   64'(ovr8), 64'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_accept_valid", 64'(if8.Out_Valid_Out), 64'd0);
        chk("t4_data_retained", 64'(if8.Parallel_Data_Out), 64'h96);

        // sync on the would-be completing edge emits nothing
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_cnt7", 64'(cnt8), 64'd7);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_sync_no_word", 64'(if8.Out_Valid_Out), 64'd0);
        chk("t5_sync_cnt",     64'(cnt8), 64'd1);
        chk("t5_sync_sr",      64'(sr8), 64'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_sync_only_cnt", 64'(cnt8), 64'd0);

        // 5 bits, then resync with a 1 as the new first bit
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5_cnt1",  64'(cnt8), 64'd1);
        chk("t5_sr80",  64'(sr8), 64'h80);
        chk("t5_msb_sr01", 64'(sr8m), 64'h01);
        exp_q.push_back(8'h01);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sb_check8("t5_word");
        chk("t5_valid", 64'(if8.Out_Valid_Out), 64'd1);

        // asynchronous reset between edges, then a 5-bit word
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        shift_en = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_sr5",    64'(sr5), 64'd0);
        chk("t6_rst_cnt5",   64'(cnt5), 64'd0);
        chk("t6_rst_data5",  64'(if5.Parallel_Data_Out), 64'd0);
        chk("t6_rst_valid5", 64'(if5.Out_Valid_Out), 64'd0);
        chk("t6_rst_ovr5",   64'(ovr5), 64'd0);
        chk("t6_rst_valid8", 64'(if8.Out_Valid_Out), 64'd0);
        chk("t6_rst_data8",  64'(if8.Parallel_Data_Out), 64'd0);
        #1;
        rst = 1'b0;
        exp5_q.push_back(8'h1F);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t6_cnt4",   64'(cnt5), 64'd4);
        chk("t6_valid4", 64'(if5.Out_Valid_Out), 64'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        sb_check5("t6_word5");
        chk("t6_valid5", 64'(if5.Out_Valid_Out), 64'd1);
        chk("t6_cnt5_wrap", 64'(cnt5), 64'd0);
        chk("t6_ovr5", 64'(ovr5), 64'd0);

        chk("sb_drained", 64'(exp_q.size() + exp5_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
